// File: rtl/mem_sim_responder.sv
// Simulated memory/MMIO slave for a simple valid/ready core bus: RAM, console byte port,
// halt register, and a fault flag for unmapped accesses, with a fixed response latency.
module mem_sim_responder #(
    parameter int          MEM_WORDS    = 16384,
    parameter int          WAIT_CYCLES  = 1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h2000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        console_valid,
    output logic [7:0]  console_data,
    output logic        halted,
    output logic [31:0] halt_code,
    output logic        bus_fault,
    output logic [31:0] fetch_count
);

    localparam int          AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);
    localparam logic [3:0]  WAIT_LAST   = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_waitCnt;
    logic [29:0] r_wordAddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_instr;
    logic [31:0] r_mem [0:MEM_WORDS-1];
    logic        r_halted;
    logic [31:0] r_haltCode;
    logic        r_busFault;
    logic [31:0] r_fetchCount;

    logic        w_accept;
    logic        w_resp;
    logic        w_isWrite;
    logic        w_isRam;
    logic        w_isConsole;
    logic        w_isHalt;
    logic        w_isUnmapped;
    logic [AW-1:0] w_ramIdx;
    logic [31:0] w_ramWord;

    assign w_accept     = (r_state == S_IDLE) && mem_valid;
    assign w_resp       = (r_state == S_RESP);
    assign w_isWrite    = |r_wstrb;
    assign w_isRam      = {2'b00, r_wordAddr} < MEM_WORDS_L;
    assign w_isConsole  = !w_isRam && (r_wordAddr == CONSOLE_ADDR[31:2]);
    assign w_isHalt     = !w_isRam && !w_isConsole && (r_wordAddr == HALT_ADDR[31:2]);
    assign w_isUnmapped = !w_isRam && !w_isConsole && !w_isHalt;
    assign w_ramIdx     = r_wordAddr[AW-1:0];
    assign w_ramWord    = r_mem[w_ramIdx];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_waitCnt <= 4'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= (r_state == S_WAIT) ? r_waitCnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (mem_valid) w_nextState = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_waitCnt == WAIT_LAST) w_nextState = S_RESP;
            S_RESP: w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Request is captured once so the core may drop or change its inputs while we stall.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wordAddr <= mem_addr[31:2];
            r_wdata    <= mem_wdata;
            r_wstrb    <= mem_wstrb;
            r_instr    <= mem_instr;
        end
    end

    // RAM has no reset so program images survive a core reset.
    always_ff @(posedge clk) begin
        if (!reset && w_resp && w_isRam) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) r_mem[w_ramIdx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted     <= 1'b0;
            r_haltCode   <= 32'd0;
            r_busFault   <= 1'b0;
            r_fetchCount <= 32'd0;
        end else if (w_resp) begin
            if (w_isHalt && w_isWrite) begin
                r_halted   <= 1'b1;
                r_haltCode <= r_wdata;
            end
            if (w_isUnmapped) r_busFault <= 1'b1;
            if (r_instr) r_fetchCount <= r_fetchCount + 32'd1;
        end
    end

    always_comb begin
        mem_rdata = 32'd0;
        if (w_resp && !w_isWrite) begin
            if (w_isRam)       mem_rdata = w_ramWord;
            else if (w_isHalt) mem_rdata = r_haltCode;
        end
    end

    assign mem_ready     = w_resp;
    assign console_valid = w_resp && w_isConsole && w_isWrite;
    assign console_data  = console_valid ? r_wdata[7:0] : 8'd0;
    assign halted        = r_halted;
    assign halt_code     = r_haltCode;
    assign bus_fault     = r_busFault;
    assign fetch_count   = r_fetchCount;

endmodule
